// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the ROM/RAM arbiter between the
// instruction and data MMUs.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        REG_ROM  = 2'd0,
        REG_RAM  = 2'd1,
        REG_NONE = 2'd2
    } region_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    localparam logic [31:0] DEF_ROM_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_RAM_BASE = 32'h0001_0000;

    typedef struct packed {
        grant_e      grant;
        logic        write;
        logic        fault;
        region_e     region;
        logic [31:0] wdata;
    } txn_t;

    function automatic logic is_illegal(
        input region_e region,
        input logic    misaligned,
        input logic    rd,
        input logic    wr
    );
        return misaligned
            | (region == REG_NONE)
            | (rd & wr)
            | (wr & (region == REG_ROM));
    endfunction

endpackage

// File: rtl/mem_arbiter_region_decode.sv
// Combinational byte-address decode into ROM / RAM / unmapped plus an
// alignment flag. ROM wins if the two windows overlap.
module mem_region_decode
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ROM_ADDR_WIDTH = 8,
    parameter int unsigned RAM_ADDR_WIDTH = 8,
    parameter logic [31:0] ROM_BASE       = DEF_ROM_BASE,
    parameter logic [31:0] RAM_BASE       = DEF_RAM_BASE
) (
    input  logic [31:0] addr,
    output region_e     region,
    output logic        misaligned
);

    localparam logic [32:0] ROM_SIZE = 33'd4 << ROM_ADDR_WIDTH;
    localparam logic [32:0] RAM_SIZE = 33'd4 << RAM_ADDR_WIDTH;

    logic [32:0] rom_off;
    logic [32:0] ram_off;

    // 33-bit offsets: an address below the base borrows into bit 32,
    // which always lands at or above any legal region size.
    always_comb begin
        rom_off    = {1'b0, addr} - {1'b0, ROM_BASE};
        ram_off    = {1'b0, addr} - {1'b0, RAM_BASE};
        misaligned = (addr[1:0] != 2'b00);
        region     = REG_NONE;
        if (rom_off < ROM_SIZE) begin
            region = REG_ROM;
        end else if (ram_off < RAM_SIZE) begin
            region = REG_RAM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one ROM and one RAM port between the
// instruction and data MMUs; IDLE -> ACCESS -> RESP per transaction.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ROM_ADDR_WIDTH = 8,
    parameter int unsigned RAM_ADDR_WIDTH = 8,
    parameter logic [31:0] ROM_BASE       = DEF_ROM_BASE,
    parameter logic [31:0] RAM_BASE       = DEF_RAM_BASE
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      i_read_enable,
    input  logic                      i_write_enable,
    input  logic [31:0]               i_address,
    input  logic [31:0]               i_data_in,
    output logic [31:0]               i_data_out,
    output logic                      i_mem_ready,
    output logic                      i_fault,

    input  logic                      d_read_enable,
    input  logic                      d_write_enable,
    input  logic [31:0]               d_address,
    input  logic [31:0]               d_data_in,
    output logic [31:0]               d_data_out,
    output logic                      d_mem_ready,
    output logic                      d_fault,

    output logic                      rom_read_enable,
    output logic [ROM_ADDR_WIDTH-1:0] rom_address,
    input  logic [31:0]               rom_data_out,

    output logic                      ram_read_enable,
    output logic                      ram_write_enable,
    output logic [RAM_ADDR_WIDTH-1:0] ram_address,
    output logic [31:0]               ram_data_in,
    input  logic [31:0]               ram_data_out
);

    state_e                    state_q, state_d;
    grant_e                    last_grant_q, last_grant_d;
    txn_t                      txn_q, txn_d;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;

    logic        i_req;
    logic        d_req;
    grant_e      sel;
    logic [31:0] mux_addr;
    logic [31:0] mux_wdata;
    logic        mux_rd;
    logic        mux_wr;
    region_e     dec_region;
    logic        dec_misaligned;

    assign i_req = i_read_enable | i_write_enable;
    assign d_req = d_read_enable | d_write_enable;

    always_comb begin
        sel = GNT_I;
        if (i_req && d_req) begin
            sel = (last_grant_q == GNT_I) ? GNT_D : GNT_I;
        end else if (d_req) begin
            sel = GNT_D;
        end
    end

    always_comb begin
        mux_addr  = i_address;
        mux_wdata = i_data_in;
        mux_rd    = i_read_enable;
        mux_wr    = i_write_enable;
        if (sel == GNT_D) begin
            mux_addr  = d_address;
            mux_wdata = d_data_in;
            mux_rd    = d_read_enable;
            mux_wr    = d_write_enable;
        end
    end

    mem_region_decode #(
        .ROM_ADDR_WIDTH (ROM_ADDR_WIDTH),
        .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH),
        .ROM_BASE       (ROM_BASE),
        .RAM_BASE       (RAM_BASE)
    ) u_decode (
        .addr       (mux_addr),
        .region     (dec_region),
        .misaligned (dec_misaligned)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        txn_d        = txn_q;
        rom_addr_d   = rom_addr_q;
        ram_addr_d   = ram_addr_q;
        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    txn_d.grant  = sel;
                    txn_d.write  = mux_wr;
                    txn_d.region = dec_region;
                    txn_d.wdata  = mux_wdata;
                    txn_d.fault  = is_illegal(dec_region, dec_misaligned,
                                              mux_rd, mux_wr);
                    rom_addr_d   = mux_addr[ROM_ADDR_WIDTH+1:2];
                    ram_addr_d   = mux_addr[RAM_ADDR_WIDTH+1:2];
                    last_grant_d = sel;
                    state_d      = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_D;
            txn_q        <= '0;
            rom_addr_q   <= '0;
            ram_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            txn_q        <= txn_d;
            rom_addr_q   <= rom_addr_d;
            ram_addr_q   <= ram_addr_d;
        end
    end

    logic        do_access;
    logic        in_resp;
    logic [31:0] rd_data;

    // Strobes and responses depend only on registered state, so a fault
    // never reaches the memories and reset silences everything at once.
    always_comb begin
        do_access        = (state_q == ACCESS) && !txn_q.fault;
        in_resp          = (state_q == RESP);
        rom_read_enable  = do_access && (txn_q.region == REG_ROM);
        ram_read_enable  = do_access && (txn_q.region == REG_RAM)
                           && !txn_q.write;
        ram_write_enable = do_access && (txn_q.region == REG_RAM)
                           && txn_q.write;
        rom_address      = rom_read_enable ? rom_addr_q : '0;
        ram_address      = (ram_read_enable || ram_write_enable)
                           ? ram_addr_q : '0;
        ram_data_in      = ram_write_enable ? txn_q.wdata : '0;

        rd_data = '0;
        if (!txn_q.fault && !txn_q.write) begin
            rd_data = (txn_q.region == REG_ROM) ? rom_data_out
                                                : ram_data_out;
        end

        i_mem_ready = in_resp && (txn_q.grant == GNT_I);
        d_mem_ready = in_resp && (txn_q.grant == GNT_D);
        i_fault     = i_mem_ready && txn_q.fault;
        d_fault     = d_mem_ready && txn_q.fault;
        i_data_out  = i_mem_ready ? rd_data : '0;
        d_data_out  = d_mem_ready ? rd_data : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with behavioural synchronous ROM/RAM
// models and hand-computed expectations.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_read_enable, i_write_enable;
    logic [31:0] i_address, i_data_in, i_data_out;
    logic        i_mem_ready, i_fault;
    logic        d_read_enable, d_write_enable;
    logic [31:0] d_address, d_data_in, d_data_out;
    logic        d_mem_ready, d_fault;
    logic        rom_read_enable;
    logic [7:0]  rom_address;
    logic [31:0] rom_data_out;
    logic        ram_read_enable, ram_write_enable;
    logic [7:0]  ram_address;
    logic [31:0] ram_data_in, ram_data_out;

    int checks;
    int errors;

    logic [31:0] rom_mem [256];
    logic [31:0] ram_mem [256];

    mem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .i_read_enable    (i_read_enable),
        .i_write_enable   (i_write_enable),
        .i_address        (i_address),
        .i_data_in        (i_data_in),
        .i_data_out       (i_data_out),
        .i_mem_ready      (i_mem_ready),
        .i_fault          (i_fault),
        .d_read_enable    (d_read_enable),
        .d_write_enable   (d_write_enable),
        .d_address        (d_address),
        .d_data_in        (d_data_in),
        .d_data_out       (d_data_out),
        .d_mem_ready      (d_mem_ready),
        .d_fault          (d_fault),
        .rom_read_enable  (rom_read_enable),
        .rom_address      (rom_address),
        .rom_data_out     (rom_data_out),
        .ram_read_enable  (ram_read_enable),
        .ram_write_enable (ram_write_enable),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_data_out     (ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rom_read_enable) rom_data_out <= rom_mem[rom_address];
        if (ram_read_enable) ram_data_out <= ram_mem[ram_address];
        if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        i_read_enable  = 1'b0;
        i_write_enable = 1'b0;
        i_address      = '0;
        i_data_in      = '0;
        d_read_enable  = 1'b0;
        d_write_enable = 1'b0;
        d_address      = '0;
        d_data_in      = '0;
    endtask

    // kind: 0 no strobe, 1 ROM read, 2 RAM read, 3 RAM write
    task automatic run_one(input string tag, input logic side_d,
                           input logic rd, input logic wr,
                           input logic [31:0] addr,
                           input logic [31:0] wdata,
                           input int kind, input logic [7:0] waddr,
                           input logic [31:0] exp_data,
                           input logic exp_fault);
        logic rdy, flt, other;
        logic [31:0] dout;
        clear_inputs();
        if (side_d) begin
            d_read_enable  = rd;
            d_write_enable = wr;
            d_address      = addr;
            d_data_in      = wdata;
        end else begin
            i_read_enable  = rd;
            i_write_enable = wr;
            i_address      = addr;
            i_data_in      = wdata;
        end
        @(negedge clk);
        check({tag, ".rom_re"}, 32'(rom_read_enable), 32'(kind == 1));
        check({tag, ".ram_re"}, 32'(ram_read_enable), 32'(kind == 2));
        check({tag, ".ram_we"}, 32'(ram_write_enable), 32'(kind == 3));
        if (kind == 1) check({tag, ".rom_addr"}, 32'(rom_address),
                             32'(waddr));
        if (kind == 2 || kind == 3)
            check({tag, ".ram_addr"}, 32'(ram_address), 32'(waddr));
        if (kind == 3) check({tag, ".ram_din"}, ram_data_in, wdata);
        @(negedge clk);
        rdy   = side_d ? d_mem_ready : i_mem_ready;
        flt   = side_d ? d_fault     : i_fault;
        dout  = side_d ? d_data_out  : i_data_out;
        other = side_d ? i_mem_ready : d_mem_ready;
        check({tag, ".ready"}, 32'(rdy), 32'd1);
        check({tag, ".fault"}, 32'(flt), 32'(exp_fault));
        check({tag, ".data"}, dout, exp_data);
        check({tag, ".other_rdy"}, 32'(other), 32'd0);
        clear_inputs();
        @(negedge clk);
    endtask

    int          n_ev;
    logic        ev_side [4];
    int          ev_cyc  [4];
    logic        exp_side [4];
    int          exp_cyc  [4];
    int          n_rdy;

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 256; k++) begin
            rom_mem[k] = 32'hA000_0000 + 32'(k);
            ram_mem[k] = 32'h5000_0000 + 32'(k);
        end
        rom_mem[1] = 32'h0010_0093;
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst.i_ready", 32'(i_mem_ready), 32'd0);
        check("rst.d_ready", 32'(d_mem_ready), 32'd0);
        check("rst.strobes", {29'd0, rom_read_enable, ram_read_enable,
                              ram_write_enable}, 32'd0);
        check("rst.addrs", {16'd0, rom_address, ram_address}, 32'd0);
        check("rst.ram_din", ram_data_in, 32'd0);
        check("rst.i_data", i_data_out, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Continuous tie from reset: I, D, I, D, three cycles apart.
        exp_side = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_cyc  = '{2, 5, 8, 11};
        n_ev = 0;
        i_read_enable = 1'b1;
        i_address     = 32'h0000_0004;
        d_read_enable = 1'b1;
        d_address     = 32'h0001_0008;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (i_mem_ready) begin
                if (n_ev < 4) begin
                    ev_side[n_ev] = 1'b0;
                    ev_cyc[n_ev]  = c;
                end
                n_ev++;
                check("tie.i_data", i_data_out, 32'h0010_0093);
            end
            if (d_mem_ready) begin
                if (n_ev < 4) begin
                    ev_side[n_ev] = 1'b1;
                    ev_cyc[n_ev]  = c;
                end
                n_ev++;
                check("tie.d_data", d_data_out, 32'h5000_0002);
            end
        end
        clear_inputs();
        check("tie.count", 32'(n_ev), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < n_ev) begin
                check("tie.side", 32'(ev_side[k]), 32'(exp_side[k]));
                check("tie.cycle", 32'(ev_cyc[k]), 32'(exp_cyc[k]));
            end
        end
        @(negedge clk);

        run_one("i_rom", 1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0,
                1, 8'd1, 32'h0010_0093, 1'b0);
        run_one("d_wr", 1'b1, 1'b0, 1'b1, 32'h0001_0008, 32'hDEAD_BEEF,
                3, 8'd2, 32'h0, 1'b0);
        run_one("d_rd", 1'b1, 1'b1, 1'b0, 32'h0001_0008, 32'h0,
                2, 8'd2, 32'hDEAD_BEEF, 1'b0);
        run_one("rom_wr", 1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678,
                0, 8'd0, 32'h0, 1'b1);
        run_one("misal", 1'b1, 1'b1, 1'b0, 32'h0000_0011, 32'h0,
                0, 8'd0, 32'h0, 1'b1);
        run_one("unmap", 1'b1, 1'b1, 1'b0, 32'h0002_0000, 32'h0,
                0, 8'd0, 32'h0, 1'b1);
        run_one("rdwr", 1'b1, 1'b1, 1'b1, 32'h0001_0000, 32'hCAFE_0000,
                0, 8'd0, 32'h0, 1'b1);
        run_one("ram_top", 1'b0, 1'b1, 1'b0, 32'h0001_03FC, 32'h0,
                2, 8'd255, 32'h5000_00FF, 1'b0);
        run_one("ram_end", 1'b0, 1'b1, 1'b0, 32'h0001_0400, 32'h0,
                0, 8'd0, 32'h0, 1'b1);

        // Reset pulsed while an I read sits in ACCESS.
        i_read_enable = 1'b1;
        i_address     = 32'h0000_0004;
        @(negedge clk);
        check("abort.pre_strobe", 32'(rom_read_enable), 32'd1);
        reset = 1'b1;
        #1;
        check("abort.strobe", {29'd0, rom_read_enable, ram_read_enable,
                               ram_write_enable}, 32'd0);
        check("abort.rom_addr", 32'(rom_address), 32'd0);
        check("abort.ready", {30'd0, i_mem_ready, d_mem_ready}, 32'd0);
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        n_rdy = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (i_mem_ready || d_mem_ready || rom_read_enable) n_rdy++;
        end
        check("abort.silent", 32'(n_rdy), 32'd0);

        i_read_enable = 1'b1;
        i_address     = 32'h0000_0004;
        d_read_enable = 1'b1;
        d_address     = 32'h0001_0008;
        @(negedge clk);
        @(negedge clk);
        check("post.i_ready", 32'(i_mem_ready), 32'd1);
        check("post.d_ready", 32'(d_mem_ready), 32'd0);
        check("post.i_data", i_data_out, 32'h0010_0093);
        check("post.i_fault", 32'(i_fault), 32'd0);
        clear_inputs();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one ROM port and one RAM port between the instruction MMU and the data MMU.
- Round-robin arbitration between the two requesters.
- Address decode into ROM / RAM / unmapped regions.
- A 3-state transaction sequencer per access.
- Pulses a per-requester ready and fault.
Sits between the two MMUs and the synchronous ROM/RAM instances inside soc. Word accesses only.

Parameters:
- ROM_ADDR_WIDTH, 8, ROM word-address bits (region = 4*2^ROM_ADDR_WIDTH bytes).
- RAM_ADDR_WIDTH, 8, RAM word-address bits.
- ROM_BASE, 32'h0000_0000, byte base of ROM region; aligned to region size.
- RAM_BASE, 32'h0001_0000, byte base of RAM region; aligned to region size.

Ports:
Clock and reset:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.

Instruction requester:
- i_read_enable  in  1  instruction-side read request.
- i_write_enable  in  1  instruction-side write request.
- i_address  in  32  instruction-side byte address.
- i_data_in  in  32  instruction-side write data.
- i_data_out  out  32  instruction-side read data; valid only while i_mem_ready=1.
- i_mem_ready  out  1  one-cycle completion pulse.
- i_fault  out  1  one-cycle pulse with i_mem_ready on illegal access.

Data requester:
- d_read_enable, d_write_enable, d_address, d_data_in, d_data_out, d_mem_ready, d_fault: same as i_* for the data side.

ROM and RAM ports:
- rom_read_enable  out  1  ROM read strobe.
- rom_address  out  ROM_ADDR_WIDTH  ROM word address.
- rom_data_out  in  32  ROM read data; valid the cycle after the strobe.
- ram_read_enable  out  1  RAM read strobe.
- ram_write_enable  out  1  RAM write strobe.
- ram_address  out  RAM_ADDR_WIDTH  RAM word address.
- ram_data_in  out  32  RAM write data.
- ram_data_out  in  32  RAM read data; valid the cycle after the read strobe.

Behaviour:
Reset:
- On reset: state=IDLE, last_grant=D (so I wins the first tie).
- All enables, ready and fault outputs = 0; all data and address outputs = 0.
- Reset mid-transaction aborts it silently: no ready pulse, no memory strobe after reset asserts.

Request and ownership:
- Request = read_enable | write_enable, sampled only in IDLE.
- The requester holds enables, address and data stable until its ready pulse.
- The requester must deassert in the cycle after ready. An enable still high in the next IDLE cycle is a new request.

State machine (IDLE -> ACCESS -> RESP -> IDLE):
- IDLE: if any request, latch grant, op, address, wdata, region, fault -> ACCESS.
  - Only one requester active: grant it.
  - Both active: grant the one != last_grant, then update last_grant.
- ACCESS (one cycle): if no fault, assert exactly one strobe for the latched region/op.
  - rom_read_enable for ROM reads.
  - ram_read_enable or ram_write_enable for RAM accesses.
  - Addresses: rom_address / ram_address = latched address[W+1:2].
  - ram_data_in = latched wdata.
  - Always -> RESP.
- RESP (one cycle): granted requester's mem_ready=1.
  - data_out = rom_data_out or ram_data_out for a successful read; 0 for writes and faults.
  - fault=1 if latched fault.
  - Non-granted requester sees ready=0, data_out=0.
  - -> IDLE.

Latency and throughput:
- Request visible at edge N -> ready high in cycle N+2.
- One transaction per 3 cycles.
- Worst-case wait for a losing requester: one extra transaction.

Fault conditions (no memory strobe issued, ready+fault pulse):
- address[1:0] != 0.
- Address outside both regions.
- Write to the ROM region.
- read_enable and write_enable both high.

Decode:
- ROM region: ROM_BASE <= addr < ROM_BASE + 4*2^ROM_ADDR_WIDTH; RAM likewise.
- Comparisons are unsigned 32-bit.
- Region size must not overflow 32 bits.
- If regions overlap, ROM wins.

Strobe timing:
- Strobes are registered-state outputs, never combinational from requester inputs.

Decomposition:
- mem_arbiter_pkg:
  - State encoding: IDLE, ACCESS, RESP.
  - Region codes: REG_ROM, REG_RAM, REG_NONE.
  - Grant codes: GNT_I, GNT_D.
  - Default base constants.
- One sub-module, mem_region_decode: combinational address -> {region, misaligned}, parameterised by bases and widths.
- The arbiter instantiates it once, on the muxed address.

Test Plan:
- I reads 0x0000_0004 alone, ROM word1 = 0x0010_0093 -> rom_read_enable at N+1 with rom_address=1; i_mem_ready=1, i_data_out=0x0010_0093 at N+2; i_fault=0.
- D writes 0xDEAD_BEEF to 0x0001_0008, then D reads 0x0001_0008 -> ram_write_enable with ram_address=2; the read returns d_data_out=0xDEAD_BEEF.
- I and D both request continuously for 4 transactions from reset -> grant order I, D, I, D; each ready exactly 3 cycles apart.
- D writes 0x0000_0010 (ROM) -> no strobe; d_mem_ready=d_fault=1. Then D reads 0x0000_0011 (misaligned) and reads 0x0002_0000 (unmapped) -> fault each time, d_data_out=0.
- I read in flight, reset pulsed during ACCESS -> all outputs 0 immediately (async); no i_mem_ready. After release, a new I read completes normally and I wins a tie.
- D asserts read and write together at 0x0001_0000 -> no ram strobe; d_fault=1 with d_mem_ready.
